input_conditioner: RTL and testbench



---
 rtl/input_cond_pkg.sv | 15 +
 rtl/input_conditioner_debounce_bit.sv | 143 ++++++++++++++
 rtl/input_conditioner.sv | 59 +++++
 tb/tb_input_conditioner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// Shared types and default constants for the input conditioner.
package input_cond_pkg;

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    WAIT_HI = 2'd1,
    ST_HI   = 2'd2,
    WAIT_LO = 2'd3
  } deb_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_CYCLES   = 25000000;

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// Single-bit synchronizer + debouncer with edge pulses.
// Optional auto-repeat of the rise pulse for button bits when
// BTN_AUTOREPEAT_EN is defined.
module debounce_bit
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit IS_BTN          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_chain_q;
  logic [SYNC_STAGES-1:0] sync_chain_d;
  logic                   sync_q;
  deb_state_t             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   rise_q;
  logic                   fall_q;
  logic                   rep_pulse;

  assign sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], raw};
  assign sync_q       = sync_chain_q[SYNC_STAGES-1];

  // Saturating increment: the count must never wrap back to zero.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // Metastability synchronizer: shift raw level through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_chain_q <= '0;
    else        sync_chain_q <= sync_chain_d;
  end

  // Debounce FSM: a new level is accepted only after an unbroken stable run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        ST_LO: begin
          if (sync_q) begin
            state_q <= WAIT_HI;
            cnt_q   <= CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!sync_q) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_q <= ST_HI;
            cnt_q   <= '0;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_HI: begin
          if (!sync_q) begin
            state_q <= WAIT_LO;
            cnt_q   <= CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (sync_q) begin
            state_q <= ST_HI;
            cnt_q   <= '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= ST_LO;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  if (IS_BTN) begin : g_rep
    logic [REP_W-1:0] rep_cnt_q;
    logic             rep_pulse_q;

    // Repeat timer: runs only while the level is settled high; any exit clears it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt_q   <= '0;
        rep_pulse_q <= 1'b0;
      end else if (state_q == ST_HI && sync_q) begin
        if (rep_cnt_q >= REP_LAST) begin
          rep_cnt_q   <= '0;
          rep_pulse_q <= 1'b1;
        end else begin
          rep_cnt_q   <= rep_cnt_q + REP_ONE;
          rep_pulse_q <= 1'b0;
        end
      end else begin
        rep_cnt_q   <= '0;
        rep_pulse_q <= 1'b0;
      end
    end

    assign rep_pulse = rep_pulse_q;
  end else begin : g_no_rep
    assign rep_pulse = 1'b0;
  end
`else
  localparam int rep_cycles_unused = REPEAT_CYCLES;
  assign rep_pulse = 1'b0;
`endif

  assign clean = (state_q == ST_HI) || (state_q == WAIT_LO);
  assign rise  = IS_BTN ? (rise_q | rep_pulse) : 1'b0;
  assign fall  = IS_BTN ? fall_q : 1'b0;

endmodule

// File: rtl/input_conditioner.sv
// Board input front end: one synchronizer/debouncer per switch and button
// bit. Buttons additionally produce press/release pulses.
// Optional macro BTN_AUTOREPEAT_EN enables periodic press re-pulsing.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_SW            = 16,
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  swt_raw,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_SW-1:0]  swt_clean,
  output logic [N_BTN-1:0] btn_clean,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // Switch edge pulses are tied low inside the instances and not consumed.
  logic [N_SW-1:0] sw_rise_unused;
  logic [N_SW-1:0] sw_fall_unused;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .IS_BTN         (1'b0)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (swt_raw[i]),
      .clean(swt_clean[i]),
      .rise (sw_rise_unused[i]),
      .fall (sw_fall_unused[i])
    );
  end

  for (genvar j = 0; j < N_BTN; j++) begin : g_btn
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .IS_BTN         (1'b1)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_raw[j]),
      .clean(btn_clean[j]),
      .rise (btn_press[j]),
      .fall (btn_release[j])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios followed by
// randomized bouncing inputs, all compared against a run-length reference model.
module tb_input_conditioner;

  localparam int N_SW  = 16;
  localparam int N_BTN = 4;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int REP   = 8;
  localparam int NB    = N_SW + N_BTN;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_SW-1:0]  swt_raw;
  logic [N_BTN-1:0] btn_raw;
  logic [N_SW-1:0]  swt_clean;
  logic [N_BTN-1:0] btn_clean;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  int checks = 0;
  int errors = 0;

  input_conditioner #(
    .N_SW           (N_SW),
    .N_BTN          (N_BTN),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .swt_raw    (swt_raw),
    .btn_raw    (btn_raw),
    .swt_clean  (swt_clean),
    .btn_clean  (btn_clean),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // Reference model: raw delayed by SYNC edges, then a level is accepted once
  // it has disagreed with the clean level for DEB consecutive edges.
  logic [NB-1:0] m_sync [SYNC];
  logic [NB-1:0] m_clean, m_rise, m_fall, m_rep, m_stable;
  int            m_run [NB];
  int            m_age [NB];

  task automatic model_reset();
    for (int k = 0; k < SYNC; k++) m_sync[k] = '0;
    m_clean = '0; m_rise = '0; m_fall = '0; m_rep = '0; m_stable = '0;
    for (int b = 0; b < NB; b++) begin
      m_run[b] = 0;
      m_age[b] = 0;
    end
  endtask

  task automatic model_edge();
    logic [NB-1:0] raw_all;
    logic [NB-1:0] s;
    raw_all = {btn_raw, swt_raw};
    s = m_sync[SYNC-1];
    m_rise = '0; m_fall = '0; m_rep = '0;
    for (int b = 0; b < NB; b++) begin
      if (s[b] != m_clean[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_clean[b] = s[b];
          m_run[b]   = 0;
          if (s[b]) m_rise[b] = 1'b1;
          else      m_fall[b] = 1'b1;
        end
      end else begin
        m_run[b] = 0;
      end
      if (m_clean[b] && m_run[b] == 0) begin
        if (m_stable[b]) m_age[b]++;
        else             m_age[b] = 0;
        m_stable[b] = 1'b1;
        if (m_age[b] > 0 && (m_age[b] % REP) == 0) m_rep[b] = 1'b1;
      end else begin
        m_stable[b] = 1'b0;
        m_age[b]    = 0;
      end
    end
    for (int k = SYNC - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
    m_sync[0] = raw_all;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    logic [N_BTN-1:0] exp_press;
    exp_press = m_rise[NB-1:N_SW] | (REP_EN ? m_rep[NB-1:N_SW] : '0);
    chk("swt_clean", 32'(swt_clean), 32'(m_clean[N_SW-1:0]));
    chk("btn_clean", 32'(btn_clean), 32'(m_clean[NB-1:N_SW]));
    chk("btn_press", 32'(btn_press), 32'(exp_press));
    chk("btn_release", 32'(btn_release), 32'(m_fall[NB-1:N_SW]));
    chk("press_release_excl", 32'(btn_press & btn_release), 32'd0);
  endtask

  task automatic chk_all_zero();
    chk("rst_swt_clean", 32'(swt_clean), 32'd0);
    chk("rst_btn_clean", 32'(btn_clean), 32'd0);
    chk("rst_btn_press", 32'(btn_press), 32'd0);
    chk("rst_btn_release", 32'(btn_release), 32'd0);
  endtask

  // One clock edge: advance the model, then compare just after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_model();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once.
  task automatic async_reset_pulse();
    rst_n = 1'b0;
    #1;
    chk_all_zero();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] mask;
    logic [31:0] exp_mask;

    // Reset with inputs already high
    rst_n   = 1'b0;
    swt_raw = 16'hF0A5;
    btn_raw = 4'hF;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_all_zero();
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 5) chk("post_rst_btn_clean_e5", 32'(btn_clean), 32'h0);
      if (e == 6) begin
        chk("post_rst_swt_clean_e6", 32'(swt_clean), 32'hF0A5);
        chk("post_rst_btn_clean_e6", 32'(btn_clean), 32'hF);
        chk("post_rst_btn_press_e6", 32'(btn_press), 32'hF);
      end
    end
    step();
    chk("post_rst_press_one_cycle", 32'(btn_press), 32'h0);

    // Release all buttons
    btn_raw = 4'h0;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 6) begin
        chk("rel_all_btn_release", 32'(btn_release), 32'hF);
        chk("rel_all_btn_clean", 32'(btn_clean), 32'h0);
      end
    end
    step();
    chk("rel_all_one_cycle", 32'(btn_release), 32'h0);

    // Clean press on button 0
    btn_raw = 4'b0001;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 5) chk("press0_clean_e5", 32'(btn_clean), 32'h0);
      if (e == 6) begin
        chk("press0_press", 32'(btn_press), 32'h1);
        chk("press0_clean", 32'(btn_clean), 32'h1);
        chk("press0_release", 32'(btn_release), 32'h0);
      end
    end

    // Bounce on button 1: three cycles high is not enough
    btn_raw[1] = 1'b1;
    repeat (3) step();
    btn_raw[1] = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      chk("bounce1_quiet", 32'({btn_clean[1], btn_press[1], btn_release[1]}), 32'h0);
    end

    // Release button 0
    btn_raw[0] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 6) begin
        chk("rel0_release", 32'(btn_release), 32'h1);
        chk("rel0_clean", 32'(btn_clean), 32'h0);
      end
    end
    step();

    // Reset in the middle of a debounce wait
    swt_raw = 16'hFFFF;
    repeat (4) step();
    async_reset_pulse();
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e <= 5) chk("midrst_swt_low", 32'(swt_clean), 32'h0);
      else        chk("midrst_swt_high", 32'(swt_clean), 32'hFFFF);
    end

    // Long hold on button 2: press pulses (auto-repeat when enabled)
    btn_raw[2] = 1'b1;
    mask = '0;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (btn_press[2]) mask[e] = 1'b1;
    end
    exp_mask = 32'h0;
    exp_mask[6] = 1'b1;
    if (REP_EN) begin
      exp_mask[14] = 1'b1;
      exp_mask[22] = 1'b1;
      exp_mask[30] = 1'b1;
    end
    chk("hold2_press_edges", mask, exp_mask);
    btn_raw[2] = 1'b0;
    repeat (8) step();

    // Randomized bouncing on all bits with occasional async resets
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N_SW; b++)
        if ($urandom_range(0, 11) == 0) swt_raw[b] = ~swt_raw[b];
      for (int b = 0; b < N_BTN; b++)
        if ($urandom_range(0, 11) == 0) btn_raw[b] = ~btn_raw[b];
      if ($urandom_range(0, 499) == 0) async_reset_pulse();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
